// File: rtl/con_ff_unit_if.sv
// Handshake/bus bundle between the control unit and the branch-condition unit.
// Latency: wires only, no storage.
// Backpressure: none here; con_valid/con_ack carry the result handshake.
// Ports: master = control-unit side (drives strobes, IR and bus value),
//        slave  = con_ff_unit side (returns preview, CON flag, valid, stats).
interface con_ff_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  con_in;
  logic                  con_ack;
  logic                  stat_clr;
  logic [31:0]           ir_in;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  cond_now;
  logic                  con_out;
  logic                  con_valid;
  logic [CNT_WIDTH-1:0]  taken_cnt;
  logic [CNT_WIDTH-1:0]  not_taken_cnt;

  modport master (
    output con_in, con_ack, stat_clr, ir_in, bus_in,
    input  cond_now, con_out, con_valid, taken_cnt, not_taken_cnt
  );

  modport slave (
    input  con_in, con_ack, stat_clr, ir_in, bus_in,
    output cond_now, con_out, con_valid, taken_cnt, not_taken_cnt
  );
endinterface

// File: rtl/con_ff_unit.sv
// Branch-condition unit: decodes the IR condition field against the bus value and latches CON.
// Latency: cond_now is combinational; con_out/con_valid/counters update 1 cycle after con_in.
// Backpressure: none; a new capture overwrites an unacknowledged result, con_ack only drops con_valid.
// Ports: clk, clr (sync active-high reset), cif (slave modport: con_in, con_ack,
//        stat_clr, ir_in, bus_in in; cond_now, con_out, con_valid, taken_cnt, not_taken_cnt out).
module con_ff_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int COND_LSB   = 19,
  parameter int COND_BITS  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          clr,
  con_ff_unit_if.slave  cif
);

  logic [COND_BITS-1:0] cond_code;
  logic [2:0]           code3;
  logic                 z_flag;
  logic                 n_flag;
  logic                 cond_val;

  logic                 con_out_q,   con_out_d;
  logic                 con_valid_q, con_valid_d;
  logic [CNT_WIDTH-1:0] taken_q,     taken_d;
  logic [CNT_WIDTH-1:0] not_taken_q, not_taken_d;

  // Only the condition field of the IR matters here; the rest is folded away.
  logic ir_unused;
  assign ir_unused = ^cif.ir_in;

  assign cond_code = cif.ir_in[COND_LSB +: COND_BITS];
  // Zero-extend so the 2-bit legacy field can only reach codes 0-3.
  assign code3     = 3'(cond_code);
  assign z_flag    = (cif.bus_in == '0);
  assign n_flag    = cif.bus_in[DATA_WIDTH-1];

  always_comb begin
    cond_val = 1'b0;
    case (code3)
      3'd0: cond_val = z_flag;
      3'd1: cond_val = !z_flag;
      3'd2: cond_val = !n_flag;
      3'd3: cond_val = n_flag;
      3'd4: cond_val = !n_flag && !z_flag;
      3'd5: cond_val = n_flag || z_flag;
      3'd6: cond_val = 1'b1;
      3'd7: cond_val = 1'b0;
      default: cond_val = 1'b0;
    endcase
  end

  always_comb begin
    con_out_d   = con_out_q;
    con_valid_d = con_valid_q;
    taken_d     = taken_q;
    not_taken_d = not_taken_q;

    if (cif.con_in) begin
      // Capture wins over a same-cycle acknowledge.
      con_out_d   = cond_val;
      con_valid_d = 1'b1;
      if (cond_val) begin
        if (taken_q != '1) taken_d = taken_q + 1'b1;
      end else begin
        if (not_taken_q != '1) not_taken_d = not_taken_q + 1'b1;
      end
    end else if (cif.con_ack) begin
      con_valid_d = 1'b0;
    end

    // Statistics clear beats the increment but leaves the CON flag path alone.
    if (cif.stat_clr) begin
      taken_d     = '0;
      not_taken_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      con_out_q   <= con_out_d;
      con_valid_q <= con_valid_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  assign cif.cond_now      = cond_val;
  assign cif.con_out       = con_out_q;
  assign cif.con_valid     = con_valid_q;
  assign cif.taken_cnt     = taken_q;
  assign cif.not_taken_cnt = not_taken_q;

endmodule

// File: doc/con_ff_unit.md
Name: con_ff_unit

Overview:
Parametrised branch-condition unit for the datapath control path. It decodes the condition field of the IR and evaluates it against the value currently driven on the bus. The result is registered into the CON flip-flop on con_in, and a valid/ack handshake tells the control unit when the result is fresh. Saturating taken and not-taken counters are kept for branch statistics. The block replaces the fixed 4-condition, 32-bit CON logic with a width- and field-configurable version that has real clocked storage.

Parameters:
DATA_WIDTH, 32, width of bus_in; sign bit is bus_in[DATA_WIDTH-1]
COND_LSB, 19, LSB position of the condition field in ir_in
COND_BITS, 3, width of the condition field (2 gives legacy 4-condition mode, 3 gives 8 conditions)
CNT_WIDTH, 16, width of each statistics counter

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
con_in  input  1  capture strobe: evaluate the condition and load CON
con_ack  input  1  control unit has consumed the current result
stat_clr  input  1  synchronous clear of the statistics counters only
ir_in  input  32  instruction register contents
bus_in  input  DATA_WIDTH  bus value under test (Ra contents)
cond_now  output  1  combinational preview of the condition result (unregistered)
con_out  output  1  registered CON flag to the control unit
con_valid  output  1  con_out is fresh and not yet acknowledged
taken_cnt  output  CNT_WIDTH  number of captures with result 1
not_taken_cnt  output  CNT_WIDTH  number of captures with result 0

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high.
- Condition code c = ir_in[COND_LSB+COND_BITS-1 : COND_LSB]. Let z = (bus_in == 0) and n = bus_in[DATA_WIDTH-1].
- Code meanings:
  - 0: z (branch if zero)
  - 1: !z (branch if nonzero)
  - 2: !n (branch if >= 0)
  - 3: n (branch if < 0)
  - 4: !n & !z (branch if > 0)
  - 5: n | z (branch if <= 0)
  - 6: always 1
  - 7: always 0
- When COND_BITS=2, only codes 0-3 exist. COND_BITS outside {2,3} is unsupported.
- cond_now is combinational from ir_in and bus_in, with zero latency.
- Reset: while clr=1 at an edge, con_out=0, con_valid=0, taken_cnt=0 and not_taken_cnt=0. clr overrides every other input.
- Capture: on an edge with con_in=1:
  - con_out <= cond_now and con_valid <= 1.
  - If cond_now=1, taken_cnt increments by 1; otherwise not_taken_cnt increments by 1.
  - Latency is 1 cycle: con_out reflects the capture in the cycle after the strobe.
- Hold: with con_in=0, con_out keeps its value indefinitely. Bus and IR changes have no effect on it.
- Acknowledge: on an edge with con_ack=1 and con_in=0, con_valid <= 0. con_out is unchanged.
- Simultaneous con_in and con_ack: the capture wins, con_valid stays 1, and counters update.
- A con_ack while con_valid=0 has no effect.
- Back-to-back con_in on consecutive cycles: each edge re-evaluates and counts. con_valid stays 1.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. A capture at saturation leaves that counter at all-ones.
- stat_clr=1 at an edge zeroes both counters, and takes priority over the increment in the same cycle. con_out and con_valid still update from a simultaneous con_in.
- Reset mid-operation: clr asserted together with con_in clears all state, and the capture is discarded.
- Counters never change on cycles with con_in=0, unless clr or stat_clr is asserted.

Test Plan:
1. clr=1 for 2 cycles with con_in=1 and bus_in=0, code 0 → con_out=0, con_valid=0, both counters 0.
2. Code 0, bus_in=0, con_in pulsed for 1 cycle → con_out=1 and con_valid=1 on the next cycle, taken_cnt=1. Then bus_in=5 with no strobe → con_out stays 1.
3. Sweep codes 0-7 with bus_in ∈ {0x00000000, 0x00000007, 0x80000000}, one capture each → con_out follows the code table (e.g. code 4 with 0x7 gives 1; code 5 with 0x80000000 gives 1; code 7 always gives 0). taken_cnt + not_taken_cnt = 24.
4. Capture, then con_ack alone → con_valid 1→0 with con_out held. Then con_in and con_ack in the same cycle → con_valid=1 and the count increments.
5. CNT_WIDTH=4, code 6, 17 consecutive strobes → taken_cnt=15 (saturated), not_taken_cnt=0. Then stat_clr with con_in together → both counters 0, con_out=1.
6. COND_BITS=2, DATA_WIDTH=8, COND_LSB=19: ir_in[20:19]=3 with bus_in=0x80 → con_out=1; bus_in=0x7F → con_out=0.
